qs_srt_bank_sched: RTL

//   Sequences ownership of the sort-engine's N memory banks between three

---
 rtl/qs_srt_pkg.sv | 15 +
 rtl/qs_srt_bank_ptr.sv | 31 +++
 rtl/qs_srt_bank_sched.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/qs_srt_pkg.sv
// Shared types for the qs_srt sort engine: bank lifecycle states.
package qs_srt_pkg;

    localparam int BANK_STATE_W = 3;

    typedef enum logic [BANK_STATE_W-1:0] {
        FREE     = 3'd0,
        FILLING  = 3'd1,
        READY    = 3'd2,
        SORTING  = 3'd3,
        SORTED   = 3'd4,
        DRAINING = 3'd5
    } bank_state_t;

endpackage

// File: rtl/qs_srt_bank_ptr.sv
// Round-robin bank pointer: wraps modulo 2**BANK_W, advances only on inc_i.
module qs_srt_bank_ptr #(
    parameter int BANK_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc_i,
    output logic [BANK_W-1:0] ptr_o
);

    logic [BANK_W-1:0] ptr_q;
    logic [BANK_W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (inc_i) begin
            ptr_d = ptr_q + BANK_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/qs_srt_bank_sched.sv
// Bank ownership sequencer between ingress, sort engine and egress.
// Banks are issued round-robin so output order matches input order.
module qs_srt_bank_sched
    import qs_srt_pkg::*;
#(
    parameter int N_BANKS = 4,
    parameter int BANK_W  = $clog2(N_BANKS)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_alloc_req,
    output logic                          in_alloc_gnt,
    output logic [BANK_W-1:0]             in_bank,
    input  logic                          in_cmpl,
    input  logic [BANK_W-1:0]             in_cmpl_bank,
    input  logic                          eng_await,
    output logic                          eng_await_gnt,
    output logic [BANK_W-1:0]             eng_bank,
    input  logic                          eng_done,
    output logic                          eng_busy,
    input  logic                          out_alloc_req,
    output logic                          out_alloc_gnt,
    output logic [BANK_W-1:0]             out_bank,
    input  logic                          out_cmpl,
    input  logic [BANK_W-1:0]             out_cmpl_bank,
    output logic [BANK_STATE_W*N_BANKS-1:0] bank_state,
    output logic                          err
);

    bank_state_t       state_q [N_BANKS];
    bank_state_t       state_d [N_BANKS];
    logic [BANK_W-1:0] in_ptr;
    logic [BANK_W-1:0] eng_ptr;
    logic [BANK_W-1:0] out_ptr;
    logic [BANK_W-1:0] eng_bank_q;
    logic [BANK_W-1:0] eng_bank_d;
    logic              eng_busy_q;
    logic              eng_busy_d;
    logic              err_q;
    logic              err_d;

    qs_srt_bank_ptr #(.BANK_W(BANK_W)) u_in_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (in_alloc_gnt),
        .ptr_o (in_ptr)
    );

    qs_srt_bank_ptr #(.BANK_W(BANK_W)) u_eng_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (eng_await_gnt),
        .ptr_o (eng_ptr)
    );

    qs_srt_bank_ptr #(.BANK_W(BANK_W)) u_out_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (out_alloc_gnt),
        .ptr_o (out_ptr)
    );

    // Grants look only at registered state; an AWAIT while busy is illegal and never granted.
    assign in_alloc_gnt  = in_alloc_req && (state_q[in_ptr] == FREE);
    assign eng_await_gnt = eng_await && !eng_done && !eng_busy_q
                           && (state_q[eng_ptr] == READY);
    assign out_alloc_gnt = out_alloc_req && (state_q[out_ptr] == SORTED);

    always_comb begin
        state_d    = state_q;
        eng_bank_d = eng_bank_q;
        eng_busy_d = eng_busy_q;
        err_d      = err_q;

        if (in_alloc_gnt) begin
            state_d[in_ptr] = FILLING;
        end
        if (in_cmpl) begin
            if (state_q[in_cmpl_bank] == FILLING) begin
                state_d[in_cmpl_bank] = READY;
            end else begin
                err_d = 1'b1;
            end
        end

        if (eng_await_gnt) begin
            state_d[eng_ptr] = SORTING;
            eng_bank_d       = eng_ptr;
            eng_busy_d       = 1'b1;
        end
        if (eng_done) begin
            if (eng_busy_q) begin
                state_d[eng_bank_q] = SORTED;
                eng_busy_d          = 1'b0;
            end else begin
                err_d = 1'b1;
            end
        end
        if (eng_await && eng_busy_q && !eng_done) begin
            err_d = 1'b1;
        end

        if (out_alloc_gnt) begin
            state_d[out_ptr] = DRAINING;
        end
        if (out_cmpl) begin
            if (state_q[out_cmpl_bank] == DRAINING) begin
                state_d[out_cmpl_bank] = FREE;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N_BANKS; i++) begin
                state_q[i] <= FREE;
            end
            eng_bank_q <= '0;
            eng_busy_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            eng_bank_q <= eng_bank_d;
            eng_busy_q <= eng_busy_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        bank_state = '0;
        for (int unsigned i = 0; i < N_BANKS; i++) begin
            bank_state[BANK_STATE_W*i +: BANK_STATE_W] = state_q[i];
        end
    end

    assign in_bank  = in_ptr;
    assign out_bank = out_ptr;
    assign eng_bank = eng_bank_q;
    assign eng_busy = eng_busy_q;
    assign err      = err_q;

endmodule
